// File: rtl/mem_arbiter_if.sv
// Bundled IF / SLB / RAM-pin signals of the memory arbiter.
// slave is the arbiter side; master is the requester/RAM side.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_valid;
  logic [31:0] if_inst;
  logic        slb_req;
  logic [31:0] slb_addr;
  logic        slb_wr;
  logic [7:0]  slb_dout;
  logic        slb_grant;
  logic [7:0]  slb_din;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  modport slave (
    input  if_req, if_addr, slb_req, slb_addr, slb_wr, slb_dout, mem_din, io_buffer_full,
    output if_valid, if_inst, slb_grant, slb_din, mem_dout, mem_a, mem_wr
  );

  modport master (
    output if_req, if_addr, slb_req, slb_addr, slb_wr, slb_dout, mem_din, io_buffer_full,
    input  if_valid, if_inst, slb_grant, slb_din, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port byte RAM arbiter: per-byte SLB grants, 4-byte little-endian IF fetches.
// Define MEM_ARB_PREEMPT_EN to let SLB bytes interleave into an IF fetch in progress.
module mem_arbiter #(
  parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  input  logic          control_hazard,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, FETCH, LAST} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] base_q, base_d;
  logic        cap_valid_q, cap_valid_d;
  logic [1:0]  cap_idx_q, cap_idx_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] mem_a_q, mem_a_d;

  logic        io_block;
  logic        slb_window;
  logic        grant;
  logic        if_issue;
  logic [31:0] issue_addr;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      base_q      <= 32'd0;
      cap_valid_q <= 1'b0;
      cap_idx_q   <= 2'd0;
      if_inst_q   <= 32'd0;
      if_valid_q  <= 1'b0;
      mem_a_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      cap_valid_q <= cap_valid_d;
      cap_idx_q   <= cap_idx_d;
      if_inst_q   <= if_inst_d;
      if_valid_q  <= if_valid_d;
      mem_a_q     <= mem_a_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    base_d      = base_q;
    cap_valid_d = 1'b0;
    cap_idx_d   = cap_idx_q;
    if_inst_d   = if_inst_q;
    if_valid_d  = 1'b0;
    if_issue    = 1'b0;
    issue_addr  = base_q + 32'(cnt_q);

    // UART writes stall while its FIFO is full; reads to IO space are never blocked
    io_block = bus.slb_wr && (bus.slb_addr[17:16] == IO_ADDR_HI) && bus.io_buffer_full;
`ifdef MEM_ARB_PREEMPT_EN
    slb_window = (state_q == IDLE) || (state_q == FETCH);
`else
    slb_window = (state_q == IDLE);
`endif
    grant = bus.slb_req && slb_window && rdy_in && !io_block;

    // Byte returned for last cycle's IF issue; the tag keeps SLB bytes out of if_inst
    if (cap_valid_q && !control_hazard)
      if_inst_d[{cap_idx_q, 3'b000} +: 8] = bus.mem_din;

    case (state_q)
      IDLE: begin
        if (rdy_in && bus.if_req && !grant && !control_hazard) begin
          if_issue    = 1'b1;
          issue_addr  = bus.if_addr;
          base_d      = bus.if_addr;
          cnt_d       = 2'd1;
          cap_valid_d = 1'b1;
          cap_idx_d   = 2'd0;
          state_d     = FETCH;
        end
      end
      FETCH: begin
        if (control_hazard) begin
          cnt_d   = 2'd0;
          state_d = IDLE;
        end else if (rdy_in && !grant) begin
          if_issue    = 1'b1;
          cap_valid_d = 1'b1;
          cap_idx_d   = cnt_q;
          cnt_d       = cnt_q + 2'd1;
          if (cnt_q == 2'd3)
            state_d = LAST;
        end
      end
      LAST: begin
        if (control_hazard) begin
          cnt_d   = 2'd0;
          state_d = IDLE;
        end else if (rdy_in) begin
          if_valid_d = 1'b1;
          cnt_d      = 2'd0;
          state_d    = IDLE;
        end
      end
      default: begin
        cnt_d   = 2'd0;
        state_d = IDLE;
      end
    endcase

    // RAM address holds its last value when nothing is issued
    if (grant)
      mem_a_d = bus.slb_addr;
    else if (if_issue)
      mem_a_d = issue_addr;
    else
      mem_a_d = mem_a_q;
  end

  assign bus.mem_a     = mem_a_d;
  assign bus.mem_wr    = grant && bus.slb_wr;
  assign bus.mem_dout  = grant ? bus.slb_dout : 8'd0;
  assign bus.slb_grant = grant;
  assign bus.slb_din   = bus.mem_din;
  assign bus.if_valid  = if_valid_q && !control_hazard;
  assign bus.if_inst   = if_inst_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: SLB byte vectors from a table plus IF fetch sequences.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  logic rdy;
  logic hazard;
  int   checks;
  int   errors;

  mem_arbiter_if ifc ();

  mem_arbiter #(.IO_ADDR_HI(2'b11)) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .rdy_in        (rdy),
    .control_hazard(hazard),
    .bus           (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: 14-bit index {a[17:16], a[11:0]}, read-old on write, data one cycle later
  logic [7:0] ram [16384];

  function automatic logic [13:0] ridx(input logic [31:0] a);
    return {a[17:16], a[11:0]};
  endfunction

  function automatic logic [7:0] preset(input logic [13:0] i);
    case (i)
      14'h0100: return 8'h13;
      14'h0101: return 8'h05;
      14'h0200: return 8'hAB;
      14'h0300: return 8'hB7;
      14'h0301: return 8'h02;
      14'h0302: return 8'h01;
      14'h0400: return 8'h93;
      14'h0402: return 8'h10;
      14'h3FFE: return 8'h11;
      14'h3FFF: return 8'h22;
      14'h0000: return 8'h33;
      14'h0001: return 8'h44;
      default:  return 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16384; i++) ram[i] <= preset(14'(i));
    end else if (ifc.mem_wr) begin
      ram[ridx(ifc.mem_a)] <= ifc.mem_dout;
    end
    ifc.mem_din <= ram[ridx(ifc.mem_a)];
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic start_fetch(input string name, input logic [31:0] a);
    @(posedge clk); #1;
    ifc.if_req  = 1'b1;
    ifc.if_addr = a;
    #1;
    chk({name, " issue addr"}, ifc.mem_a, a);
    chk({name, " issue rd"}, 32'(ifc.mem_wr), 32'd0);
  endtask

  task automatic wait_valid(input string name, input logic [31:0] exp_inst, input int exp_lat);
    int lat;
    logic got;
    logic [31:0] inst;
    lat = 0; got = 1'b0; inst = 32'd0;
    while (!got && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (ifc.if_valid) begin
        got = 1'b1;
        inst = ifc.if_inst;
        ifc.if_req = 1'b0;
      end
    end
    chk({name, " valid seen"}, 32'(got), 32'd1);
    chk({name, " latency"}, 32'(lat), 32'(exp_lat));
    chk({name, " inst"}, inst, exp_inst);
  endtask

  typedef struct {
    logic        slb_req;
    logic        slb_wr;
    logic [31:0] slb_addr;
    logic [7:0]  slb_dout;
    logic        io_full;
    logic        rdy;
    logic        grant;
    logic        wr;
    logic [31:0] a;
    logic [7:0]  dout;
    logic [7:0]  din;
  } vec_t;

  vec_t vecs [14];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; rdy = 1'b1; hazard = 1'b0;
    ifc.if_req = 1'b0; ifc.if_addr = 32'd0;
    ifc.slb_req = 1'b0; ifc.slb_wr = 1'b0; ifc.slb_addr = 32'd0; ifc.slb_dout = 8'd0;
    ifc.io_buffer_full = 1'b0;

    //            req wr  addr         dout   full rdy  grant wr  a            dout   din
    vecs[0]  = '{1'b0, 1'b0, 32'h0,     8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,     8'h00, 8'h33};
    vecs[1]  = '{1'b1, 1'b0, 32'h200,   8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h200,   8'h00, 8'h33};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,     8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h200,   8'h00, 8'hAB};
    vecs[3]  = '{1'b1, 1'b1, 32'h210,   8'h5C, 1'b0, 1'b1, 1'b1, 1'b1, 32'h210,   8'h5C, 8'hAB};
    vecs[4]  = '{1'b1, 1'b0, 32'h210,   8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h210,   8'h00, 8'h00};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,     8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h210,   8'h00, 8'h5C};
    vecs[6]  = '{1'b1, 1'b1, 32'h30000, 8'h41, 1'b1, 1'b1, 1'b0, 1'b0, 32'h210,   8'h00, 8'h5C};
    vecs[7]  = '{1'b1, 1'b1, 32'h30000, 8'h41, 1'b1, 1'b1, 1'b0, 1'b0, 32'h210,   8'h00, 8'h5C};
    vecs[8]  = '{1'b1, 1'b1, 32'h30000, 8'h41, 1'b1, 1'b1, 1'b0, 1'b0, 32'h210,   8'h00, 8'h5C};
    vecs[9]  = '{1'b1, 1'b1, 32'h30000, 8'h41, 1'b0, 1'b1, 1'b1, 1'b1, 32'h30000, 8'h41, 8'h5C};
    vecs[10] = '{1'b1, 1'b0, 32'h30000, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 32'h30000, 8'h00, 8'h00};
    vecs[11] = '{1'b1, 1'b1, 32'h20000, 8'h77, 1'b1, 1'b1, 1'b1, 1'b1, 32'h20000, 8'h77, 8'h41};
    vecs[12] = '{1'b1, 1'b0, 32'h200,   8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h20000, 8'h00, 8'h00};
    vecs[13] = '{1'b0, 1'b0, 32'h0,     8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h20000, 8'h00, 8'h77};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset if_valid", 32'(ifc.if_valid), 32'd0);
    chk("reset if_inst", ifc.if_inst, 32'd0);
    chk("reset slb_grant", 32'(ifc.slb_grant), 32'd0);
    chk("reset mem_wr", 32'(ifc.mem_wr), 32'd0);
    chk("reset mem_a", ifc.mem_a, 32'd0);
    chk("reset mem_dout", 32'(ifc.mem_dout), 32'd0);

    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      ifc.slb_req = vecs[i].slb_req;
      ifc.slb_wr = vecs[i].slb_wr;
      ifc.slb_addr = vecs[i].slb_addr;
      ifc.slb_dout = vecs[i].slb_dout;
      ifc.io_buffer_full = vecs[i].io_full;
      rdy = vecs[i].rdy;
      #1;
      chk($sformatf("v%0d grant", i), 32'(ifc.slb_grant), 32'(vecs[i].grant));
      chk($sformatf("v%0d mem_wr", i), 32'(ifc.mem_wr), 32'(vecs[i].wr));
      chk($sformatf("v%0d mem_a", i), ifc.mem_a, vecs[i].a);
      chk($sformatf("v%0d mem_dout", i), 32'(ifc.mem_dout), 32'(vecs[i].dout));
      chk($sformatf("v%0d slb_din", i), 32'(ifc.slb_din), 32'(vecs[i].din));
      chk($sformatf("v%0d if_valid", i), 32'(ifc.if_valid), 32'd0);
    end
    @(posedge clk); #1;
    ifc.slb_req = 1'b0; ifc.slb_wr = 1'b0; ifc.io_buffer_full = 1'b0; rdy = 1'b1;

    // Plain fetch and address wrap
    start_fetch("if100", 32'h100);
    wait_valid("if100", 32'h0000_0513, 5);
    start_fetch("wrap", 32'hFFFF_FFFE);
    wait_valid("wrap", 32'h4433_2211, 5);

    // SLB beats IF in IDLE for a 4-byte access
    @(posedge clk); #1;
    ifc.slb_req = 1'b1; ifc.slb_wr = 1'b0; ifc.slb_addr = 32'h200;
    ifc.if_req = 1'b1; ifc.if_addr = 32'h100;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
        ifc.slb_addr = 32'h200 + 32'(i);
      end
      #1;
      chk($sformatf("cont grant%0d", i), 32'(ifc.slb_grant), 32'd1);
      chk($sformatf("cont addr%0d", i), ifc.mem_a, 32'h200 + 32'(i));
      if (i == 1) chk("cont din0", 32'(ifc.slb_din), 32'hAB);
    end
    @(posedge clk); #1;
    ifc.slb_req = 1'b0;
    #1;
    chk("cont fetch grant", 32'(ifc.slb_grant), 32'd0);
    chk("cont fetch addr", ifc.mem_a, 32'h100);
    wait_valid("cont", 32'h0000_0513, 5);

    // Flush two cycles into a fetch, then refetch
    start_fetch("flush", 32'h100);
    @(posedge clk); #1;
    chk("flush T+1 addr", ifc.mem_a, 32'h101);
    @(posedge clk); #1;
    hazard = 1'b1;
    #1;
    chk("flush T+2 hold addr", ifc.mem_a, 32'h101);
    chk("flush T+2 if_valid", 32'(ifc.if_valid), 32'd0);
    @(posedge clk); #1;
    hazard = 1'b0; ifc.if_addr = 32'h400;
    #1;
    chk("flush T+3 new issue", ifc.mem_a, 32'h400);
    wait_valid("refetch", 32'h0010_0093, 5);

    // SLB request arriving one cycle into a fetch
    start_fetch("pre", 32'h300);
    @(posedge clk); #1;
    ifc.slb_req = 1'b1; ifc.slb_wr = 1'b0; ifc.slb_addr = 32'h200;
    #1;
`ifdef MEM_ARB_PREEMPT_EN
    chk("pre T+1 grant", 32'(ifc.slb_grant), 32'd1);
    chk("pre T+1 addr", ifc.mem_a, 32'h200);
    @(posedge clk); #1;
    ifc.slb_req = 1'b0;
    #1;
    chk("pre T+2 din", 32'(ifc.slb_din), 32'hAB);
    chk("pre T+2 addr", ifc.mem_a, 32'h301);
    @(posedge clk); #1;
    chk("pre T+3 addr", ifc.mem_a, 32'h302);
    @(posedge clk); #1;
    chk("pre T+4 addr", ifc.mem_a, 32'h303);
    @(posedge clk); #1;
    chk("pre T+5 if_valid", 32'(ifc.if_valid), 32'd0);
    @(posedge clk); #1;
    chk("pre T+6 if_valid", 32'(ifc.if_valid), 32'd1);
    chk("pre T+6 inst", ifc.if_inst, 32'h0001_02B7);
    ifc.if_req = 1'b0;
`else
    for (int i = 1; i < 4; i++) begin
      if (i > 1) begin
        @(posedge clk); #1;
      end
      chk($sformatf("pre T+%0d grant", i), 32'(ifc.slb_grant), 32'd0);
      chk($sformatf("pre T+%0d addr", i), ifc.mem_a, 32'h300 + 32'(i));
    end
    @(posedge clk); #1;
    chk("pre T+4 grant", 32'(ifc.slb_grant), 32'd0);
    chk("pre T+4 if_valid", 32'(ifc.if_valid), 32'd0);
    @(posedge clk); #1;
    chk("pre T+5 if_valid", 32'(ifc.if_valid), 32'd1);
    chk("pre T+5 inst", ifc.if_inst, 32'h0001_02B7);
    ifc.if_req = 1'b0;
    #1;
    chk("pre T+5 grant", 32'(ifc.slb_grant), 32'd1);
    chk("pre T+5 addr", ifc.mem_a, 32'h200);
    @(posedge clk); #1;
    ifc.slb_req = 1'b0;
    #1;
    chk("pre T+6 din", 32'(ifc.slb_din), 32'hAB);
`endif
    @(posedge clk); #1;
    ifc.slb_req = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
